// File: rtl/axi_read_pkg.sv
// Shared encodings, FSM states and request legality helpers for the AXI read path.
package axi_read_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DATA,
        ERR
    } state_t;

    // Wrapping bursts must span 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; shared by read and write paths.
module axi_burst_addr_gen
    import axi_read_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] cur_addr,
    input  logic [1:0]    size,
    input  logic [3:0]    len,
    input  logic [1:0]    burst,
    output logic [AW-1:0] next_addr
);

    logic [AW-1:0] bytes;
    logic [AW-1:0] aligned;
    logic [AW-1:0] incr;
    logic [AW-1:0] total;
    logic [AW-1:0] base;

    always_comb begin
        bytes   = AW'(1) << size;
        aligned = cur_addr & ~(bytes - AW'(1));
        incr    = aligned + bytes;
        total   = bytes * (AW'(len) + AW'(1));
        base    = cur_addr & ~(total - AW'(1));
        case (burst)
            BURST_INCR: next_addr = incr;
            BURST_WRAP: next_addr = base + (incr & (total - AW'(1)));
            default:    next_addr = cur_addr;
        endcase
    end

endmodule

// File: rtl/axi_read_burst_ctrl.sv
// AXI read-slave burst sequencer: one AR at a time, one memory read per beat, R with backpressure.
module axi_read_burst_ctrl
    import axi_read_pkg::*;
#(
    parameter int unsigned BUSWIDTH = 32,
    parameter int unsigned IDW      = 2,
    parameter int unsigned MEM_AW   = 7
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [IDW-1:0]      ARID,
    input  logic [BUSWIDTH-1:0] ARADDR,
    input  logic [3:0]          ARLEN,
    input  logic [1:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [IDW-1:0]      RID,
    output logic [BUSWIDTH-1:0] RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic                mem_rd,
    input  logic [BUSWIDTH-1:0] mem_rdata
);

    localparam int unsigned NBYTES = BUSWIDTH / 8;

    state_t                state_q, state_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [BUSWIDTH-1:0]   addr_q, addr_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            beat_q, beat_d;
    logic [1:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;

    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [IDW-1:0]        rid_q, rid_d;
    logic [BUSWIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [MEM_AW-1:0]     mem_addr_q, mem_addr_d;
    logic                  mem_rd_q, mem_rd_d;

    logic [BUSWIDTH-1:0]   next_addr;
    logic [BUSWIDTH-1:0]   rdata_masked;
    logic                  ar_hs;
    logic                  ar_illegal;
    logic                  last_beat;

    axi_burst_addr_gen #(.AW(BUSWIDTH)) u_addr_gen (
        .cur_addr  (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
        end
    end

    // Next-state and next-output logic; every register holds unless a transition changes it.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        size_d     = size_q;
        burst_d    = burst_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rlast_d    = rlast_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;

        ar_hs      = ARVALID && arready_q;
        ar_illegal = (ARBURST == BURST_RSVD)
                  || ((32'd1 << ARSIZE) > NBYTES)
                  || ((ARBURST == BURST_WRAP) && !wrap_len_legal(ARLEN));
        last_beat  = (beat_q == len_q);

        // Lanes beyond the beat size read as zero.
        rdata_masked = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (i < (32'd1 << size_q)) rdata_masked[i*8 +: 8] = mem_rdata[i*8 +: 8];
        end

        case (state_q)
            IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    id_d      = ARID;
                    addr_d    = ARADDR;
                    len_d     = ARLEN;
                    size_d    = ARSIZE;
                    burst_d   = ARBURST;
                    beat_d    = 4'd0;
                    rid_d     = ARID;
                    if (ar_illegal) begin
                        state_d  = ERR;
                        rvalid_d = 1'b1;
                        rdata_d  = '0;
                        rresp_d  = RESP_SLVERR;
                        rlast_d  = (ARLEN == 4'd0);
                    end else begin
                        state_d    = READ;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = ARADDR[MEM_AW-1:0];
                    end
                end
            end
            READ: begin
                state_d  = DATA;
                rvalid_d = 1'b1;
                rdata_d  = rdata_masked;
                rresp_d  = RESP_OKAY;
                rid_d    = id_q;
                rlast_d  = last_beat;
            end
            DATA: begin
                if (RREADY) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (last_beat) begin
                        state_d   = IDLE;
                        arready_d = 1'b1;
                    end else begin
                        state_d    = READ;
                        beat_d     = beat_q + 4'd1;
                        addr_d     = next_addr;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = next_addr[MEM_AW-1:0];
                    end
                end
            end
            ERR: begin
                if (RREADY) begin
                    if (last_beat) begin
                        state_d   = IDLE;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        rlast_d = ((beat_q + 4'd1) == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ARREADY  = arready_q;
    assign RVALID   = rvalid_q;
    assign RLAST    = rlast_q;
    assign RID      = rid_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;

endmodule

// File: tb/tb_axi_read_burst_ctrl.sv
// Directed bench for axi_read_burst_ctrl: AXI-rule beat model, 128-byte RAM[i]=i, per-cycle compare.
module tb_axi_read_burst_ctrl;

    logic        ACLK;
    logic        ARESETn;
    logic [1:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [1:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [1:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic [6:0]  mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;

    axi_read_burst_ctrl dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Test memory: RAM[i] = i, read word updates on the falling edge.
    logic [7:0] ram [128];
    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 8'(i);
        mem_rdata = '0;
    end
    always @(negedge ACLK) begin
        if (mem_rd)
            mem_rdata <= {ram[7'(mem_addr + 7'd3)], ram[7'(mem_addr + 7'd2)],
                          ram[7'(mem_addr + 7'd1)], ram[mem_addr]};
    end

    typedef struct packed {
        logic [6:0]  maddr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [1:0]  id;
        logic        last;
        logic        err;
    } beat_t;

    beat_t       q[$];
    logic [31:0] data_log[$];
    logic [6:0]  maddr_log[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          exp_total = 0;
    int          since_rst = 0;
    int          reads = 0;
    int          gaps = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [6:0] a, input int unsigned nb);
        logic [31:0] w;
        w = '0;
        for (int unsigned b = 0; b < 4; b++)
            if (b < nb) w[b*8 +: 8] = 8'(7'(a + 7'(b)));
        return w;
    endfunction

    // Expected beats straight from the burst rules (closed form per beat index).
    task automatic build(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] size, input logic [1:0] burst);
        logic [31:0] bytes, total, aligned, base, a;
        logic        illegal;
        beat_t       bt;
        bytes   = 32'd1 << size;
        total   = bytes * (32'(len) + 32'd1);
        aligned = addr & ~(bytes - 32'd1);
        base    = addr & ~(total - 32'd1);
        illegal = (burst == 2'd3) || (size == 2'd3) ||
                  (burst == 2'd2 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
        for (int k = 0; k <= int'(len); k++) begin
            if (k == 0 || burst == 2'd0) a = addr;
            else if (burst == 2'd1)      a = aligned + 32'(k) * bytes;
            else                         a = base + ((aligned - base + 32'(k) * bytes) % total);
            bt.maddr = a[6:0];
            bt.id    = id;
            bt.last  = (k == int'(len));
            bt.err   = illegal;
            bt.data  = illegal ? 32'd0 : exp_word(a[6:0], bytes);
            bt.resp  = illegal ? 2'b10 : 2'b00;
            q.push_back(bt);
        end
        exp_total = int'(len) + 1;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            check("reset_outputs", 64'({ARREADY, RVALID, RLAST, mem_rd, RID, RRESP, mem_addr, RDATA}), 64'd0);
            q.delete();
            since_rst = 0;
            reads = 0;
            gaps = 0;
        end else begin
            if (since_rst < 2) since_rst++;
            check("arready", 64'(ARREADY), 64'((q.size() == 0) && (since_rst >= 2)));
            if (mem_rd) begin
                if (RVALID || q.size() == 0 || q[0].err) check("mem_rd_spurious", 64'(mem_rd), 64'd0);
                else begin
                    check("mem_addr", 64'(mem_addr), 64'(q[0].maddr));
                    maddr_log.push_back(mem_addr);
                end
                reads++;
            end
            if (RVALID) begin
                if (q.size() == 0) check("extra_beat", 64'(RVALID), 64'd0);
                else begin
                    check("rdata", 64'(RDATA), 64'(q[0].data));
                    check("rid", 64'(RID), 64'(q[0].id));
                    check("rresp", 64'(RRESP), 64'(q[0].resp));
                    check("rlast", 64'(RLAST), 64'(q[0].last));
                    if (RREADY) begin
                        check("reads_per_beat", 64'(reads), q[0].err ? 64'd0 : 64'd1);
                        check("beat_latency_gap", 64'(gaps), q[0].err ? 64'd0 : 64'd1);
                        data_log.push_back(RDATA);
                        void'(q.pop_front());
                        reads = 0;
                        gaps = 0;
                    end
                end
            end else if (q.size() != 0) begin
                gaps++;
            end
        end
    end

    task automatic issue(input logic [1:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] size, input logic [1:0] burst);
        int t = 0;
        while (!ARREADY && t < 50) begin
            @(posedge ACLK); #2;
            t++;
        end
        if (!ARREADY) check("arready_timeout", 64'(ARREADY), 64'd1);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        @(posedge ACLK); #2;
        ARVALID = 1'b0;
        data_log.delete();
        maddr_log.delete();
        build(id, addr, len, size, burst);
    endtask

    task automatic drain(input int stall_beat, input int stall_n);
        int t = 0;
        int left = stall_n;
        while (q.size() > 0 && t < 300) begin
            if (RVALID && (exp_total - q.size()) == stall_beat && left > 0) begin
                RREADY = 1'b0;
                left--;
            end else begin
                RREADY = 1'b1;
            end
            @(posedge ACLK); #2;
            t++;
        end
        RREADY = 1'b1;
        if (q.size() > 0) check("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge ACLK); #2;
    endtask

    task automatic check_data(input string name, input int idx, input logic [31:0] exp);
        if (idx < data_log.size()) check(name, 64'(data_log[idx]), 64'(exp));
        else check({name, "_missing"}, 64'(data_log.size()), 64'(idx + 1));
    endtask

    task automatic check_maddr(input string name, input int idx, input logic [6:0] exp);
        if (idx < maddr_log.size()) check(name, 64'(maddr_log[idx]), 64'(exp));
        else check({name, "_missing"}, 64'(maddr_log.size()), 64'(idx + 1));
    endtask

    initial begin
        ARESETn = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0;
        ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #2 ARESETn = 1'b1;
        @(posedge ACLK); #2;

        // INCR with 3-cycle stall on beat 2
        issue(2'd1, 32'h08, 4'd2, 2'd2, 2'd1);
        drain(1, 3);
        check_data("t1_b0", 0, 32'h0B0A0908);
        check_data("t1_b1", 1, 32'h0F0E0D0C);
        check_data("t1_b2", 2, 32'h13121110);

        issue(2'd0, 32'h00, 4'd3, 2'd0, 2'd1);
        drain(-1, 0);
        for (int i = 0; i < 4; i++) begin
            check_data("t2_data", i, 32'(i));
            check_maddr("t2_maddr", i, 7'(i));
        end

        issue(2'd3, 32'h18, 4'd3, 2'd2, 2'd2);
        drain(-1, 0);
        check_maddr("t3_m0", 0, 7'h18);
        check_maddr("t3_m1", 1, 7'h1C);
        check_maddr("t3_m2", 2, 7'h10);
        check_maddr("t3_m3", 3, 7'h14);
        check_data("t3_b2", 2, 32'h13121110);
        check_data("t3_b3", 3, 32'h17161514);

        issue(2'd2, 32'h05, 4'd1, 2'd1, 2'd0);
        drain(-1, 0);
        check_data("t4_b0", 0, 32'h00000605);
        check_data("t4_b1", 1, 32'h00000605);
        check_maddr("t4_m1", 1, 7'h05);

        // Two-beat wrap from an odd byte, and upper address bits dropped on the memory side
        issue(2'd1, 32'h41, 4'd1, 2'd0, 2'd2);
        drain(-1, 0);
        check_maddr("wrap2_m1", 1, 7'h40);
        issue(2'd0, 32'h1000_007F, 4'd1, 2'd0, 2'd1);
        drain(-1, 0);
        check_data("memwrap_b0", 0, 32'h0000007F);
        check_maddr("memwrap_m1", 1, 7'h00);

        // Illegal requests: reserved burst, bad wrap length, oversize beat
        issue(2'd2, 32'h20, 4'd1, 2'd2, 2'd3);
        drain(0, 2);
        check("err_beats", 64'(data_log.size()), 64'd2);
        check_data("err_b1", 1, 32'h0);
        issue(2'd1, 32'h00, 4'd2, 2'd2, 2'd2);
        drain(-1, 0);
        check("badwrap_beats", 64'(data_log.size()), 64'd3);
        issue(2'd3, 32'h00, 4'd0, 2'd3, 2'd1);
        drain(-1, 0);
        check("size3_beats", 64'(data_log.size()), 64'd1);

        // Reset in the middle of a WRAP burst, then a normal burst
        begin
            int t = 0;
            issue(2'd3, 32'h18, 4'd3, 2'd2, 2'd2);
            while (!((exp_total - q.size()) == 1 && RVALID) && t < 50) begin
                @(posedge ACLK); #2;
                t++;
            end
            check("abort_reached_beat2", 64'(RVALID), 64'd1);
            ARESETn = 1'b0;
            #1;
            check("async_reset_clear", 64'({ARREADY, RVALID, RLAST, mem_rd, RID, RRESP, mem_addr, RDATA}), 64'd0);
            repeat (2) @(posedge ACLK);
            #2 ARESETn = 1'b1;
            repeat (2) @(posedge ACLK);
            #2;
            check("arready_after_reset", 64'(ARREADY), 64'd1);
        end
        issue(2'd0, 32'h00, 4'd3, 2'd0, 2'd1);
        drain(-1, 0);
        check_data("post_rst_b3", 3, 32'h00000003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
